// File: rtl/logistic_pkg.sv
// Shared widths, fixed-point constants and FSM states for the logistic-map bank.
package logistic_pkg;

    localparam int XW_DEF   = 16;
    localparam int MUW_DEF  = XW_DEF + 2;
    localparam int ONE_Q    = 1 << XW_DEF;
    localparam int MU_ONE_Q = 1 << XW_DEF;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_DONE
    } state_t;

endpackage

// File: rtl/logistic_step.sv
// One logistic-map step y = mu*x*(1-x), floor-truncating fixed point.
import logistic_pkg::*;

module logistic_step #(
    parameter int XW  = XW_DEF,
    parameter int MUW = XW + 2
) (
    input  logic [XW-1:0]  i_x,
    input  logic [MUW-1:0] i_mu,
    output logic [XW-1:0]  o_y
);

    logic [XW:0]         w_om;
    logic [2*XW:0]       w_prod;
    logic [XW-1:0]       w_t;
    logic [MUW+XW-1:0]   w_my;

    // x=0 yields om=2^XW, hence the extra bit
    assign w_om   = {1'b1, {XW{1'b0}}} - {1'b0, i_x};
    assign w_prod = (2*XW+1)'(i_x) * (2*XW+1)'(w_om);
    assign w_t    = w_prod[2*XW-1:XW];
    assign w_my   = (MUW+XW)'(i_mu) * (MUW+XW)'(w_t);
    // t <= 2^(XW-2) and mu < 4.0 keep y inside XW bits
    assign o_y    = w_my[2*XW-1:XW];

endmodule

// File: rtl/logistic_bank.sv
// N-channel time-multiplexed logistic-map engine with registered readback.
// Optional per-channel min/max tracking: define LOGISTIC_MINMAX_EN.
import logistic_pkg::*;

module logistic_bank #(
    parameter int N_CH      = 4,
    parameter int XW        = XW_DEF,
    parameter int MUW       = XW + 2,
    parameter int IT_W      = 16,
    parameter int SEED_STEP = 1,
    localparam int IW       = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            start,
    input  logic [MUW-1:0]  mu,
    input  logic [XW-1:0]   seed,
    input  logic [IT_W-1:0] n_iter,
    output logic            busy,
    output logic            done,
    input  logic [IW-1:0]   rd_idx,
    output logic [XW-1:0]   rd_data
`ifdef LOGISTIC_MINMAX_EN
    ,
    output logic [XW-1:0]   rd_min,
    output logic [XW-1:0]   rd_max
`endif
);

    state_t          r_state;
    state_t          w_next;
    logic [MUW-1:0]  r_mu;
    logic [XW-1:0]   r_seed;
    logic [IT_W-1:0] r_n_iter;
    logic [IT_W-1:0] r_it;
    logic [IW-1:0]   r_ch;
    logic [XW-1:0]   r_x [N_CH];
    logic            w_accept;
    logic            w_last_ch;
    logic            w_last_it;
    logic            w_rd_ok;
    logic [XW-1:0]   w_x_cur;
    logic [XW-1:0]   w_y;

    assign w_accept  = start && (r_state == S_IDLE || r_state == S_DONE);
    assign w_last_ch = (r_ch == IW'(N_CH - 1));
    assign w_last_it = ((r_it + 1'b1) == r_n_iter);
    assign w_rd_ok   = (int'(rd_idx) < N_CH);
    assign w_x_cur   = r_x[r_ch];

    logistic_step #(
        .XW  (XW),
        .MUW (MUW)
    ) u_step (
        .i_x  (w_x_cur),
        .i_mu (r_mu),
        .o_y  (w_y)
    );

    always_ff @(posedge CLK) begin
        if (RST) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        busy   = 1'b0;
        done   = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (w_accept) w_next = S_LOAD;
            end
            S_LOAD: begin
                busy   = 1'b1;
                w_next = (r_n_iter == '0) ? S_DONE : S_RUN;
            end
            S_RUN: begin
                busy = 1'b1;
                if (w_last_ch && w_last_it) w_next = S_DONE;
            end
            S_DONE: begin
                done   = 1'b1;
                w_next = w_accept ? S_LOAD : S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_mu     <= '0;
            r_seed   <= '0;
            r_n_iter <= '0;
            r_ch     <= '0;
            r_it     <= '0;
            for (int k = 0; k < N_CH; k++) r_x[k] <= '0;
        end else begin
            if (w_accept) begin
                r_mu     <= mu;
                r_seed   <= seed;
                r_n_iter <= n_iter;
            end
            if (r_state == S_LOAD) begin
                for (int k = 0; k < N_CH; k++)
                    r_x[k] <= r_seed + XW'(k * SEED_STEP);
                r_ch <= '0;
                r_it <= '0;
            end else if (r_state == S_RUN) begin
                r_x[r_ch] <= w_y;
                if (w_last_ch) begin
                    r_ch <= '0;
                    r_it <= r_it + 1'b1;
                end else begin
                    r_ch <= r_ch + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST)          rd_data <= '0;
        else if (w_rd_ok) rd_data <= r_x[rd_idx];
        else              rd_data <= '0;
    end

`ifdef LOGISTIC_MINMAX_EN
    logic [XW-1:0] r_min [N_CH];
    logic [XW-1:0] r_max [N_CH];

    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int k = 0; k < N_CH; k++) begin
                r_min[k] <= '0;
                r_max[k] <= '0;
            end
        end else if (r_state == S_LOAD) begin
            for (int k = 0; k < N_CH; k++) begin
                r_min[k] <= '1;
                r_max[k] <= '0;
            end
        end else if (r_state == S_RUN) begin
            if (w_y < r_min[r_ch]) r_min[r_ch] <= w_y;
            if (w_y > r_max[r_ch]) r_max[r_ch] <= w_y;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST || !w_rd_ok) begin
            rd_min <= '0;
            rd_max <= '0;
        end else begin
            rd_min <= r_min[rd_idx];
            rd_max <= r_max[rd_idx];
        end
    end
`endif

endmodule
